// File: rtl/order_tx_scheduler.sv
// Streams a captured buy and/or sell order frame (9 words each) to a ready/valid sink,
// then pulses o_ack to release the parser and counts completed orders.
module order_tx_scheduler #(
  parameter int REG_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_order_valid,
  input  logic [9*REG_WIDTH-1:0] i_buy_regs,
  input  logic [9*REG_WIDTH-1:0] i_sell_regs,
  input  logic [1:0]             i_side_mask,
  input  logic                   i_enable,
  input  logic                   i_tx_ready,
  output logic [REG_WIDTH-1:0]   o_tx_data,
  output logic                   o_tx_valid,
  output logic                   o_tx_last,
  output logic                   o_tx_side,
  output logic                   o_ack,
  output logic                   o_busy,
  output logic [15:0]            o_sent_count
);

  // state  | meaning
  // IDLE   | waiting for an enabled, valid order
  // SEND_B | streaming captured buy words 0..8
  // SEND_S | streaming captured sell words 0..8
  // ACK    | one-cycle acknowledge to the parser
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND_B = 2'd1;
  localparam logic [1:0] S_SEND_S = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [1:0]             mask_q, mask_d;
  logic                   discard_q, discard_d;
  logic [15:0]            count_q, count_d;
  logic [9*REG_WIDTH-1:0] buy_q, buy_d, sell_q, sell_d;
  logic [REG_WIDTH-1:0]   buy_word, sell_word;
  logic                   sending, tx_fire;

  assign sending = (state_q == S_SEND_B) || (state_q == S_SEND_S);
  assign tx_fire = sending && i_tx_ready;

  always_comb begin
    buy_word  = '0;
    sell_word = '0;
    for (int k = 0; k < 9; k++) begin
      if (idx_q == k[3:0]) begin
        buy_word  = buy_q[k*REG_WIDTH +: REG_WIDTH];
        sell_word = sell_q[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    discard_d = discard_q;
    count_d   = count_q;
    buy_d     = buy_q;
    sell_d    = sell_q;
    case (state_q)
      S_IDLE: begin
        if (i_order_valid && i_enable) begin
          if (i_side_mask != 2'b00) begin
            buy_d     = i_buy_regs;
            sell_d    = i_sell_regs;
            mask_d    = i_side_mask;
            idx_d     = 4'd0;
            discard_d = 1'b0;
            state_d   = i_side_mask[0] ? S_SEND_B : S_SEND_S;
          end else begin
            // empty mask: acknowledge so the parser drops the order, but do not count it
            discard_d = 1'b1;
            state_d   = S_ACK;
          end
        end
      end
      S_SEND_B: begin
        if (tx_fire) begin
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = mask_q[1] ? S_SEND_S : S_ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_SEND_S: begin
        if (tx_fire) begin
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        if (!discard_q) count_d = count_q + 16'd1;
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      discard_q <= 1'b0;
      count_q   <= '0;
      buy_q     <= '0;
      sell_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      buy_q     <= buy_d;
      sell_q    <= sell_d;
    end
  end

  assign o_tx_valid   = sending;
  assign o_tx_side    = (state_q == S_SEND_S);
  assign o_tx_last    = sending && (idx_q == 4'd8);
  assign o_tx_data    = (state_q == S_SEND_B) ? buy_word :
                        (state_q == S_SEND_S) ? sell_word : '0;
  assign o_ack        = (state_q == S_ACK);
  assign o_busy       = (state_q != S_IDLE);
  assign o_sent_count = count_q;

endmodule

// File: tb/tb_order_tx_scheduler.sv
// Randomized bench for order_tx_scheduler: an expected-beat queue built from the order
// rules is compared against the DUT stream, plus directed reset/discard/wrap cases.
module tb_order_tx_scheduler;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           order_valid;
  logic [9*W-1:0] buy_regs, sell_regs;
  logic [1:0]     side_mask;
  logic           enable, tx_ready;
  logic [W-1:0]   tx_data;
  logic           tx_valid, tx_last, tx_side, ack, busy;
  logic [15:0]    sent_count;

  always #5 clk = ~clk;

  order_tx_scheduler #(.REG_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_order_valid(order_valid),
    .i_buy_regs(buy_regs), .i_sell_regs(sell_regs), .i_side_mask(side_mask),
    .i_enable(enable), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .o_tx_last(tx_last), .o_tx_side(tx_side),
    .o_ack(ack), .o_busy(busy), .o_sent_count(sent_count)
  );

  typedef struct {
    logic         side;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] buy_w[9], sell_w[9];
  logic [15:0]  exp_count = 16'd0;
  int           n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic load_words(input bit pattern);
    for (int k = 0; k < 9; k++) begin
      buy_w[k]  = pattern ? (32'hB000_0000 + k) : $urandom;
      sell_w[k] = pattern ? (32'h5000_0000 + k) : $urandom;
    end
  endtask

  // rmode: 0 = ready always 1, 1 = ready pattern 1,0,0,1, 2 = random ready
  // rst_beat >= 0 asserts reset while that beat index is on the bus
  task automatic run_order(input logic [1:0] mask, input int rmode, input bit corrupt,
                           input int rst_beat);
    int  cyc, beats, nbeats;
    bit  r, aborted;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      buy_regs[k*W +: W]  = buy_w[k];
      sell_regs[k*W +: W] = sell_w[k];
    end
    side_mask   = mask;
    order_valid = 1'b1;
    enable      = 1'b1;
    exp_q.delete();
    for (int s = 0; s < 2; s++)
      if (mask[s])
        for (int k = 0; k < 9; k++)
          exp_q.push_back('{side: s[0], last: (k == 8), data: (s == 0) ? buy_w[k] : sell_w[k]});
    nbeats = exp_q.size();
    @(negedge clk);
    order_valid = 1'b0;
    enable      = 1'($urandom_range(0, 1));
    if (corrupt) begin
      buy_regs  = '1;
      sell_regs = '1;
    end
    cyc = 1; beats = 0; aborted = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      chk("beat", {31'd0, tx_valid, tx_side, tx_last, tx_data},
          {31'd0, 1'b1, exp_q[0].side, exp_q[0].last, exp_q[0].data});
      if (beats == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {tx_valid, tx_last, tx_side, ack, busy, tx_data, sent_count}, 64'd0);
        exp_count = 16'd0;
        exp_q.delete();
        aborted = 1;
        break;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      if (r) begin
        void'(exp_q.pop_front());
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("timeout", 64'd1, 64'd0);
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("rst_no_ack", {ack, busy, tx_valid}, 64'd0);
      end
      rst = 1'b0;
      return;
    end
    chk("ack", {ack, busy, tx_valid, tx_data}, {1'b1, 1'b1, 1'b0, 32'd0});
    if (rmode == 0) chk("latency", cyc, nbeats + 1);
    if (rmode == 1) chk("handshakes", beats, nbeats);
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    chk("idle", {ack, busy, tx_valid, tx_data}, 64'd0);
    chk("count", sent_count, exp_count);
  endtask

  initial begin
    rst = 1'b1; order_valid = 1'b0; buy_regs = '0; sell_regs = '0;
    side_mask = 2'b00; enable = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {tx_valid, tx_last, tx_side, ack, busy, tx_data, sent_count}, 64'd0);
    rst = 1'b0;

    load_words(1'b1);
    run_order(2'b11, 0, 1'b0, -1);
    run_order(2'b10, 0, 1'b0, -1);
    run_order(2'b11, 1, 1'b0, -1);
    run_order(2'b11, 0, 1'b1, -1);
    run_order(2'b11, 0, 1'b0, 4);
    run_order(2'b11, 0, 1'b0, -1);

    // empty mask: acknowledged but not counted
    @(negedge clk);
    order_valid = 1'b1; enable = 1'b1; side_mask = 2'b00;
    @(negedge clk);
    order_valid = 1'b0;
    chk("discard_ack", {ack, busy, tx_valid}, {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("discard_idle", {ack, busy}, 64'd0);
    chk("discard_count", sent_count, exp_count);

    // disabled: a valid order must not start
    order_valid = 1'b1; enable = 1'b0; side_mask = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("disabled_idle", {busy, tx_valid, ack}, 64'd0);
    order_valid = 1'b0;

    // counter wrap
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    exp_count = 16'hFFFF;
    run_order(2'b01, 0, 1'b0, -1);
    chk("wrap", sent_count, 16'h0000);

    for (int t = 0; t < 20; t++) begin
      load_words(1'b0);
      run_order(2'(($urandom_range(0, 2)) + 1), 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
